adc_scan_scheduler: RTL and testbench

//  Sequences the single shared 12-bit ADC between the player-1 and player-2 grip sensors.
//  On each sample tick it requests a conversion per active channel over a start/done handshake.
//  It smooths each result and presents stable p1data/p2data with valid strobes to the level/screen logic.

---
 rtl/game_pkg.sv | 18 +
 rtl/level_iir.sv | 36 +++
 rtl/adc_scan_scheduler.sv | 170 +++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the grip-sensor ADC scan path and level mapping.
package game_pkg;

    localparam int unsigned ADC_W   = 12;
    localparam int unsigned SHIFT_W = 4;

    localparam logic CH_P1 = 1'b0;
    localparam logic CH_P2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STORE,
        NEXT
    } scan_state_t;

endpackage

// File: rtl/level_iir.sv
// First-order IIR smoother for one grip channel; the first sample after reset loads directly.
module level_iir
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [ADC_W-1:0]   x,
    input  logic [SHIFT_W-1:0] shift,
    output logic [ADC_W-1:0]   y,
    output logic               primed
);

    logic signed [ADC_W:0] diff_c;
    logic signed [ADC_W:0] step_c;
    logic [ADC_W-1:0]      y_next_c;

    // y + ((x - y) >>> shift); both operands are in range, so the sum never leaves 0..4095
    always_comb begin
        diff_c   = $signed({1'b0, x}) - $signed({1'b0, y});
        step_c   = diff_c >>> shift;
        y_next_c = ADC_W'($signed({1'b0, y}) + step_c);
    end

    // Filter state: unprimed after reset, first load primes with the raw sample
    always_ff @(posedge clk) begin
        if (reset) begin
            y      <= '0;
            primed <= 1'b0;
        end else if (load) begin
            y      <= primed ? y_next_c : x;
            primed <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// Time-shares the single ADC between the two grip sensors and publishes smoothed levels.
module adc_scan_scheduler
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 48000,
    parameter int unsigned DONE_TMO  = 1024,
    parameter int unsigned AVG_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    output logic             adc_start,
    output logic             adc_chan,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] p1data,
    output logic [ADC_W-1:0] p2data,
    output logic             p1_valid,
    output logic             p2_valid,
    output logic             tmo_err,
    output logic             ovr_err
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMO_W  = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
    localparam logic [SHIFT_W-1:0] FILT_SHIFT = SHIFT_W'(AVG_SHIFT);

    scan_state_t state;
    scan_state_t next_state;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_cnt_next;
    logic              chan;
    logic              chan_next;
    logic              frame_mode;
    logic              frame_mode_next;
    logic [ADC_W-1:0]  sample;
    logic [ADC_W-1:0]  sample_next;
    logic              tmo_set_c;
    logic              ovr_set_c;
    logic              load_p1_c;
    logic              load_p2_c;
    logic [1:0]        unused_primed;

    assign tick_c   = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign adc_chan = chan;

    // Free-running frame timer, independent of the scan state
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Scan state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control for one scan frame
    always_comb begin
        next_state      = state;
        chan_next       = chan;
        frame_mode_next = frame_mode;
        tmo_cnt_next    = tmo_cnt;
        sample_next     = sample;
        tmo_set_c       = 1'b0;
        ovr_set_c       = tick_c && (state != IDLE);
        load_p1_c       = 1'b0;
        load_p2_c       = 1'b0;

        case (state)
            IDLE: begin
                if (tick_c) begin
                    frame_mode_next = mode;
                    chan_next       = CH_P1;
                    next_state      = REQ;
                end
            end
            REQ: begin
                tmo_cnt_next = '0;
                next_state   = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still counts
                if (adc_done) begin
                    sample_next = adc_data;
                    next_state  = STORE;
                end else if (tmo_cnt == TMO_W'(DONE_TMO - 1)) begin
                    tmo_set_c  = 1'b1;
                    next_state = NEXT;
                end else begin
                    tmo_cnt_next = tmo_cnt + TMO_W'(1);
                end
            end
            STORE: begin
                load_p1_c  = (chan == CH_P1);
                load_p2_c  = (chan == CH_P2);
                next_state = NEXT;
            end
            NEXT: begin
                if (frame_mode && (chan == CH_P1)) begin
                    chan_next  = CH_P2;
                    next_state = REQ;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered handshake, strobes and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            chan       <= CH_P1;
            frame_mode <= 1'b0;
            tmo_cnt    <= '0;
            sample     <= '0;
            adc_start  <= 1'b0;
            p1_valid   <= 1'b0;
            p2_valid   <= 1'b0;
            tmo_err    <= 1'b0;
            ovr_err    <= 1'b0;
        end else begin
            chan       <= chan_next;
            frame_mode <= frame_mode_next;
            tmo_cnt    <= tmo_cnt_next;
            sample     <= sample_next;
            adc_start  <= (next_state == REQ);
            p1_valid   <= load_p1_c;
            p2_valid   <= load_p2_c;
            tmo_err    <= tmo_err | tmo_set_c;
            ovr_err    <= ovr_err | ovr_set_c;
        end
    end

    level_iir u_p1_iir (
        .clk    (clk),
        .reset  (reset),
        .load   (load_p1_c),
        .x      (sample),
        .shift  (FILT_SHIFT),
        .y      (p1data),
        .primed (unused_primed[0])
    );

    level_iir u_p2_iir (
        .clk    (clk),
        .reset  (reset),
        .load   (load_p2_c),
        .x      (sample),
        .shift  (FILT_SHIFT),
        .y      (p2data),
        .primed (unused_primed[1])
    );

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed + randomized bench for adc_scan_scheduler with an ADC responder and a level reference model.
module tb_adc_scan_scheduler;

    localparam int TICK = 16;
    localparam int TMO  = 8;
    localparam int SH   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode = 1'b0;
    logic        adc_start;
    logic        adc_chan;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic [11:0] p1data;
    logic [11:0] p2data;
    logic        p1_valid;
    logic        p2_valid;
    logic        tmo_err;
    logic        ovr_err;

    adc_scan_scheduler #(
        .TICK_DIV  (TICK),
        .DONE_TMO  (TMO),
        .AVG_SHIFT (SH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .adc_start (adc_start),
        .adc_chan  (adc_chan),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .p1data    (p1data),
        .p2data    (p2data),
        .p1_valid  (p1_valid),
        .p2_valid  (p2_valid),
        .tmo_err   (tmo_err),
        .ovr_err   (ovr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // ADC behaviour per channel and reference-model state
    int          lat[2];
    bit          mute[2];
    logic [11:0] val[2];

    typedef struct {
        int ch;
        int v;
        int at;
    } exp_t;

    exp_t        exp_q[$];
    int          y_m[2];
    bit          pr_m[2];
    logic [11:0] shown[2];
    int          n_start[2];
    int          n_valid[2];
    int          tmo_at = -1;
    int          busy_until = -1;
    bit          pend = 1'b0;
    bit          stale = 1'b0;
    int          cnt = 0;
    int          req_lat = 0;
    logic        req_ch = 1'b0;
    int          rel = 0;

    // Smoothed level: floor((x - y) / 2^SH) added to y, raw x on the first sample
    function automatic int smooth(input bit primed, input int y, input int x);
        int d;
        int w;
        int q;
        if (!primed) return x;
        d = x - y;
        w = 1 << SH;
        if (d >= 0) q = d / w;
        else        q = -((-d + w - 1) / w);
        return y + q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC responder plus continuous checks against the reference model
    initial begin : agent
        bit          just;
        bit          hit;
        logic        v;
        logic [11:0] d;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            just = 1'b0;
            if (reset) begin
                if (pend) stale = 1'b1;
                for (int c = 0; c < 2; c++) begin
                    y_m[c] = 0; pr_m[c] = 1'b0; shown[c] = 12'h000;
                end
                exp_q.delete();
                tmo_at = -1;
                busy_until = -1;
            end else begin
                tests++;
                assert (!(exp_q.size() > 0 && exp_q[0].at < cyc)) else begin
                    fails++;
                    $error("FAIL missing_update: ch%0d value %0h due cycle %0d not seen", exp_q[0].ch, exp_q[0].v, exp_q[0].at);
                    exp_q.pop_front();
                end
                for (int c = 0; c < 2; c++) begin
                    v = (c == 0) ? p1_valid : p2_valid;
                    d = (c == 0) ? p1data : p2data;
                    if (v) begin
                        n_valid[c]++;
                        hit = exp_q.size() > 0 && exp_q[0].ch == c && exp_q[0].at == cyc;
                        tests++;
                        assert (hit) else begin
                            fails++;
                            $error("FAIL valid_timing: ch%0d valid at cycle %0d data %0h not expected", c, cyc, d);
                        end
                        if (hit) begin
                            tests++;
                            assert (d === 12'(exp_q[0].v)) else begin
                                fails++;
                                $error("FAIL level_value: ch%0d observed %0h expected %0h", c, d, exp_q[0].v);
                            end
                            shown[c] = 12'(exp_q[0].v);
                            exp_q.pop_front();
                        end else begin
                            shown[c] = d;
                        end
                    end
                    tests++;
                    assert (d === shown[c]) else begin
                        fails++;
                        $error("FAIL level_hold: ch%0d observed %0h expected %0h", c, d, shown[c]);
                        shown[c] = d;
                    end
                end
                if (tmo_at < 0 || cyc < tmo_at) begin
                    tests++;
                    assert (tmo_err === 1'b0) else begin
                        fails++;
                        $error("FAIL tmo_early: observed %b expected 0 at cycle %0d", tmo_err, cyc);
                    end
                end else if (cyc > tmo_at) begin
                    tests++;
                    assert (tmo_err === 1'b1) else begin
                        fails++;
                        $error("FAIL tmo_missing: observed %b expected 1 at cycle %0d", tmo_err, cyc);
                    end
                end
                if (adc_start === 1'b1) begin
                    tests++;
                    assert (cyc > busy_until) else begin
                        fails++;
                        $error("FAIL start_overlap: start at cycle %0d, previous busy until %0d", cyc, busy_until);
                    end
                    req_ch = adc_chan;
                    req_lat = lat[req_ch];
                    n_start[req_ch]++;
                    just = 1'b1;
                    if (mute[req_ch] || req_lat > TMO) begin
                        busy_until = cyc + TMO;
                        if (tmo_at < 0) tmo_at = cyc + TMO;
                    end else begin
                        busy_until = cyc + req_lat;
                    end
                    pend = !mute[req_ch];
                    stale = 1'b0;
                    cnt = req_lat;
                end else if (cyc <= busy_until) begin
                    tests++;
                    assert (adc_chan === req_ch) else begin
                        fails++;
                        $error("FAIL chan_hold: observed %b expected %b at cycle %0d", adc_chan, req_ch, cyc);
                    end
                end
            end
            if (pend && !just) begin
                cnt--;
                if (cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = val[req_ch];
                    pend = 1'b0;
                    if (!stale && req_lat <= TMO) begin
                        y_m[req_ch] = smooth(pr_m[req_ch], y_m[req_ch], int'(val[req_ch]));
                        pr_m[req_ch] = 1'b1;
                        exp_q.push_back('{ch: int'(req_ch), v: y_m[req_ch], at: cyc + 2});
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output logic ch, output int at, output bit ok);
        ok = 1'b0; ch = 1'b0; at = 0;
        for (int i = 0; i < 4 * TICK && !ok; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                ok = 1'b1; ch = adc_chan; at = cyc;
            end
        end
    endtask

    task automatic wait_valid(input int c, output logic [11:0] d, output int at, output bit ok);
        ok = 1'b0; d = 12'h000; at = 0;
        for (int i = 0; i < 4 * TICK && !ok; i++) begin
            @(negedge clk);
            if (((c == 0) ? p1_valid : p2_valid) === 1'b1) begin
                ok = 1'b1; d = (c == 0) ? p1data : p2data; at = cyc;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rel = cyc;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        ch;
        logic [11:0] d;
        int          at;
        int          at2;
        bit          ok;
        int          s0;
        int          s1;
        int          v0;
        int          v1;
        logic [11:0] hold;

        lat[0] = 3; lat[1] = 3;
        mute[0] = 1'b0; mute[1] = 1'b0;
        val[0] = 12'h800; val[1] = 12'h800;
        for (int c = 0; c < 2; c++) begin n_start[c] = 0; n_valid[c] = 0; end

        // Reset state and single-player scanning
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        rel = cyc;
        chk("rst_adc_start", 32'(adc_start), 32'd0);
        chk("rst_p1data", 32'(p1data), 32'd0);
        chk("rst_p2data", 32'(p2data), 32'd0);
        chk("rst_valids", 32'({p1_valid, p2_valid}), 32'd0);
        chk("rst_errs", 32'({tmo_err, ovr_err}), 32'd0);
        wait_start(ch, at, ok);
        chk("t1_start_seen", 32'(ok), 32'd1);
        chk("t1_start_after_tick", 32'(at - rel), 32'(TICK));
        chk("t1_start_chan", 32'(ch), 32'd0);
        wait_valid(0, d, at2, ok);
        chk("t1_prime_seen", 32'(ok), 32'd1);
        chk("t1_prime_value", 32'(d), 32'h800);
        wait_cycles(TICK);
        s0 = n_start[0]; s1 = n_start[1]; v0 = n_valid[0]; v1 = n_valid[1];
        wait_cycles(4 * TICK);
        chk("t1_ch0_starts", 32'(n_start[0] - s0), 32'd4);
        chk("t1_ch1_starts", 32'(n_start[1] - s1), 32'd0);
        chk("t1_p1_valids", 32'(n_valid[0] - v0), 32'd4);
        chk("t1_p2_valids", 32'(n_valid[1] - v1), 32'd0);

        // Multiplayer priming and filter convergence
        mode = 1'b1;
        val[0] = 12'h400; val[1] = 12'hC00;
        do_reset();
        wait_valid(0, d, at2, ok);
        chk("t2_p1_prime", 32'(d), 32'h400);
        wait_valid(1, d, at2, ok);
        chk("t2_p2_prime", 32'(d), 32'hC00);
        @(posedge clk); #1;
        val[0] = 12'h800;
        wait_valid(0, d, at2, ok);
        chk("t2_p1_step1", 32'(d), 32'h500);
        wait_valid(0, d, at2, ok);
        chk("t2_p1_step2", 32'(d), 32'h5C0);
        wait_valid(0, d, at2, ok);
        chk("t2_p1_step3", 32'(d), 32'h650);
        chk("t2_p2_steady", 32'(p2data), 32'hC00);

        // Done arriving on the last allowed cycle is accepted
        mode = 1'b0;
        wait_cycles(2 * TICK);
        lat[0] = TMO;
        val[0] = 12'($urandom_range(0, 4095));
        wait_cycles(TICK);
        wait_start(ch, at, ok);
        chk("tb_start_chan", 32'(ch), 32'd0);
        wait_valid(0, d, at2, ok);
        chk("tb_update_seen", 32'(ok), 32'd1);
        chk("tb_update_latency", 32'(at2 - at), 32'(TMO + 2));
        chk("tb_no_tmo", 32'(tmo_err), 32'd0);
        chk("t2_no_ovr", 32'(ovr_err), 32'd0);

        // Silent channel 1 times out while channel 0 keeps updating
        lat[0] = 1; lat[1] = 1;
        mute[1] = 1'b1;
        val[0] = 12'($urandom_range(0, 4095));
        val[1] = 12'($urandom_range(0, 4095));
        mode = 1'b1;
        ch = 1'b0;
        for (int i = 0; i < 4 && ch !== 1'b1; i++) wait_start(ch, at, ok);
        chk("t3_ch1_requested", 32'(ch), 32'd1);
        hold = p2data;
        repeat (TMO - 1) @(negedge clk);
        chk("t3_tmo_not_yet", 32'(tmo_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("t3_tmo_set", 32'(tmo_err), 32'd1);
        wait_cycles(TICK);
        s1 = n_start[1]; v0 = n_valid[0]; v1 = n_valid[1];
        wait_cycles(4 * TICK);
        chk("t3_ch1_still_requested", 32'(n_start[1] - s1), 32'd4);
        chk("t3_p1_updates", 32'(n_valid[0] - v0), 32'd4);
        chk("t3_p2_no_updates", 32'(n_valid[1] - v1), 32'd0);
        chk("t3_p2_holds", 32'(p2data), 32'(hold));
        chk("t3_tmo_sticky", 32'(tmo_err), 32'd1);
        chk("t3_no_ovr", 32'(ovr_err), 32'd0);

        // Slow ADC stretches a two-channel frame past the next tick
        mute[1] = 1'b0;
        lat[0] = TMO - 1; lat[1] = TMO - 1;
        wait_cycles(4 * TICK);
        chk("t4_ovr_set", 32'(ovr_err), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_start(ch, at, ok);
            if (ch === 1'b1) wait_start(ch, at, ok);
            chk("t4_frame_first_ch0", 32'(ch), 32'd0);
            wait_start(ch, at, ok);
            chk("t4_frame_then_ch1", 32'(ch), 32'd1);
        end

        // Mode change during WAIT only affects the following frame
        mode = 1'b0;
        lat[0] = 3; lat[1] = 3;
        wait_cycles(3 * TICK);
        wait_start(ch, at, ok);
        chk("t5_single_start", 32'(ch), 32'd0);
        @(posedge clk); #1;
        mode = 1'b1;
        wait_start(ch, at2, ok);
        chk("t5_no_ch1_this_frame", 32'(ch), 32'd0);
        chk("t5_next_frame_spacing", 32'(at2 - at), 32'(TICK));
        wait_start(ch, at, ok);
        chk("t5_next_frame_ch1", 32'(ch), 32'd1);

        // Reset during WAIT; the late done must not land anywhere
        mode = 1'b0;
        lat[0] = 5; lat[1] = 5;
        val[0] = 12'($urandom_range(1, 4095));
        wait_cycles(2 * TICK);
        wait_start(ch, at, ok);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rel = cyc;
        chk("t6_adc_start", 32'(adc_start), 32'd0);
        chk("t6_p1data", 32'(p1data), 32'd0);
        chk("t6_p2data", 32'(p2data), 32'd0);
        chk("t6_errs_clear", 32'({tmo_err, ovr_err}), 32'd0);
        wait_cycles(5);
        chk("t6_stale_ignored", 32'(p1data), 32'd0);
        wait_start(ch, at, ok);
        chk("t6_restart_after_tick", 32'(at - rel), 32'(TICK));
        wait_valid(0, d, at2, ok);
        chk("t6_reprime", 32'(d), 32'(val[0]));

        // Randomized soak: mode, latency and data vary freely
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            mode = 1'($urandom_range(0, 1));
            lat[0] = $urandom_range(1, 4);
            lat[1] = $urandom_range(1, 4);
            val[0] = 12'($urandom_range(0, 4095));
            val[1] = 12'($urandom_range(0, 4095));
            wait_cycles($urandom_range(TICK / 2, 2 * TICK));
        end
        mode = 1'b0;
        lat[0] = 3;
        wait_cycles(2 * TICK);
        wait_valid(0, d, at2, ok);
        wait_cycles(2);
        chk("end_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("end_no_tmo", 32'(tmo_err), 32'd0);
        chk("end_no_ovr", 32'(ovr_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
